// File: rtl/ppu_oam_writer.sv
// PPU sprite RAM write-side controller: CPU OAMADDR/OAMDATA writes and $4014 DMA.
// Owns the spram write port and holds writes off while the sprite loader is busy.
module ppu_oam_writer #(
    parameter int DMA_LEN = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        reg_wr_en,
    input  logic [2:0]  reg_addr,
    input  logic [7:0]  reg_wr_data,
    input  logic        dma_start,
    input  logic [7:0]  dma_page,
    output logic        bus_rd_en,
    output logic [15:0] bus_addr,
    input  logic [7:0]  bus_rd_data,
    input  logic        bus_rd_valid,
    input  logic        loader_busy,
    output logic        spram_wr_en,
    output logic [7:0]  spram_wr_addr,
    output logic [7:0]  spram_wr_data,
    output logic [7:0]  oam_addr,
    output logic        cpu_halt,
    output logic        dma_busy,
    output logic        oam_drop
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HALT,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    localparam logic [8:0] LAST_IDX = 9'(DMA_LEN - 1);

    state_t      state_q, state_d;
    logic [8:0]  idx_q, idx_d;
    logic [7:0]  page_q, page_d;
    logic [7:0]  byte_q, byte_d;
    logic        pend_q, pend_d;
    logic [7:0]  pend_addr_q, pend_addr_d;
    logic [7:0]  pend_data_q, pend_data_d;
    logic [7:0]  oam_addr_q, oam_addr_d;
    logic        wr_en_q, wr_en_d;
    logic [7:0]  wr_addr_q, wr_addr_d;
    logic [7:0]  wr_data_q, wr_data_d;
    logic        rd_en_q, rd_en_d;
    logic [15:0] bus_addr_q, bus_addr_d;
    logic        halt_q, halt_d;
    logic        drop_q, drop_d;
    logic        reg_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            page_q      <= '0;
            byte_q      <= '0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
            pend_data_q <= '0;
            oam_addr_q  <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_en_q     <= 1'b0;
            bus_addr_q  <= '0;
            halt_q      <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            page_q      <= page_d;
            byte_q      <= byte_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
            pend_data_q <= pend_data_d;
            oam_addr_q  <= oam_addr_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_en_q     <= rd_en_d;
            bus_addr_q  <= bus_addr_d;
            halt_q      <= halt_d;
            drop_q      <= drop_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        page_d      = page_q;
        byte_d      = byte_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        pend_data_d = pend_data_q;
        oam_addr_d  = oam_addr_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_en_d     = 1'b0;
        bus_addr_d  = bus_addr_q;
        drop_d      = 1'b0;
        reg_ok      = reg_wr_en && (state_q == S_IDLE);

        if (pend_q && !loader_busy) begin
            wr_en_d   = 1'b1;
            wr_addr_d = pend_addr_q;
            wr_data_d = pend_data_q;
            pend_d    = 1'b0;
        end

        if (reg_ok && reg_addr == 3'd3) begin
            oam_addr_d = reg_wr_data;
        end

        // An idle loader takes the byte straight away; otherwise it parks.
        if (reg_ok && reg_addr == 3'd4) begin
            if (pend_q) begin
                drop_d = 1'b1;
            end else begin
                oam_addr_d = oam_addr_q + 8'd1;
                if (loader_busy) begin
                    pend_d      = 1'b1;
                    pend_addr_d = oam_addr_q;
                    pend_data_d = reg_wr_data;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = oam_addr_q;
                    wr_data_d = reg_wr_data;
                end
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (dma_start) begin
                    page_d  = dma_page;
                    idx_d   = '0;
                    state_d = S_HALT;
                end
            end
            S_HALT: state_d = S_READ;
            S_READ: state_d = S_WAIT;
            S_WAIT: begin
                if (bus_rd_valid) begin
                    byte_d  = bus_rd_data;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (!loader_busy && !pend_q) begin
                    wr_en_d    = 1'b1;
                    wr_addr_d  = oam_addr_q;
                    wr_data_d  = byte_q;
                    oam_addr_d = oam_addr_q + 8'd1;
                    idx_d      = idx_q + 9'd1;
                    state_d    = (idx_q == LAST_IDX) ? S_DONE : S_READ;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_READ) begin
            rd_en_d    = 1'b1;
            bus_addr_d = {page_q, idx_d[7:0]};
        end
        halt_d = (state_d != S_IDLE);
    end

    assign bus_rd_en     = rd_en_q;
    assign bus_addr      = bus_addr_q;
    assign spram_wr_en   = wr_en_q;
    assign spram_wr_addr = wr_addr_q;
    assign spram_wr_data = wr_data_q;
    assign oam_addr      = oam_addr_q;
    assign cpu_halt      = halt_q;
    assign dma_busy      = halt_q;
    assign oam_drop      = drop_q;

endmodule

// File: tb/tb_ppu_oam_writer.sv
// Bench for ppu_oam_writer: scoreboard of expected spram writes,
// bus responder with variable latency, directed register and DMA steps.
module tb_ppu_oam_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        reg_wr_en;
    logic [2:0]  reg_addr;
    logic [7:0]  reg_wr_data;
    logic        dma_start;
    logic [7:0]  dma_page;
    logic        bus_rd_en;
    logic [15:0] bus_addr;
    logic [7:0]  bus_rd_data;
    logic        bus_rd_valid;
    logic        loader_busy;
    logic        spram_wr_en;
    logic [7:0]  spram_wr_addr;
    logic [7:0]  spram_wr_data;
    logic [7:0]  oam_addr;
    logic        cpu_halt;
    logic        dma_busy;
    logic        oam_drop;

    ppu_oam_writer #(.DMA_LEN(256)) dut (
        .clk          (clk),
        .rst          (rst),
        .reg_wr_en    (reg_wr_en),
        .reg_addr     (reg_addr),
        .reg_wr_data  (reg_wr_data),
        .dma_start    (dma_start),
        .dma_page     (dma_page),
        .bus_rd_en    (bus_rd_en),
        .bus_addr     (bus_addr),
        .bus_rd_data  (bus_rd_data),
        .bus_rd_valid (bus_rd_valid),
        .loader_busy  (loader_busy),
        .spram_wr_en  (spram_wr_en),
        .spram_wr_addr(spram_wr_addr),
        .spram_wr_data(spram_wr_data),
        .oam_addr     (oam_addr),
        .cpu_halt     (cpu_halt),
        .dma_busy     (dma_busy),
        .oam_drop     (oam_drop)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int drop_cnt = 0;
    int halt_cycles = 0;
    int lat_max = 0;
    logic busy_mode = 1'b0;
    logic busy_force = 1'b0;
    logic busy_s = 1'b0;
    logic outstanding = 1'b0;
    logic [7:0] exp_page = 8'h00;
    logic [7:0] m_oam = 8'h00;
    logic [15:0] exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus responder: data is the low address byte xor 0x5A.
    initial begin
        int lat;
        logic [7:0] d;
        bus_rd_valid = 1'b0;
        bus_rd_data  = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (bus_rd_en) begin
                d   = bus_addr[7:0] ^ 8'h5A;
                lat = 1 + $urandom_range(0, lat_max);
                repeat (lat) @(posedge clk);
                #1;
                bus_rd_valid = 1'b1;
                bus_rd_data  = d;
                @(posedge clk);
                #1;
                bus_rd_valid = 1'b0;
            end
        end
    end

    initial begin
        loader_busy = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            loader_busy = busy_mode ? ($urandom_range(0, 3) == 0) : busy_force;
        end
    end

    always @(posedge clk) busy_s <= loader_busy;

    always @(negedge clk) begin
        logic [15:0] e;
        if (!rst) begin
            outstanding = 1'b0;
        end else begin
            if (cpu_halt) halt_cycles++;
            if (oam_drop) drop_cnt++;
            if (bus_rd_valid) outstanding = 1'b0;
            if (bus_rd_en) begin
                chk("rd_while_outstanding", 32'(outstanding), 32'd0);
                chk("bus_page", 32'(bus_addr[15:8]), 32'(exp_page));
                outstanding = 1'b1;
            end
            if (spram_wr_en) begin
                wr_cnt++;
                chk("wr_while_busy", 32'(busy_s), 32'd0);
                chk("wr_expected", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("spram_addr_data",
                        32'({spram_wr_addr, spram_wr_data}), 32'(e));
                end
            end
        end
    end

    task automatic reg_write(input logic [2:0] a, input logic [7:0] d);
        @(negedge clk);
        reg_wr_en   = 1'b1;
        reg_addr    = a;
        reg_wr_data = d;
        @(negedge clk);
        reg_wr_en   = 1'b0;
    endtask

    task automatic push_dma(input logic [7:0] start);
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back({8'(start + 8'(i)), 8'(i) ^ 8'h5A});
        end
    endtask

    task automatic dma(input logic [7:0] page);
        exp_page = page;
        push_dma(m_oam);
        halt_cycles = 0;
        @(negedge clk);
        dma_start = 1'b1;
        dma_page  = page;
        @(negedge clk);
        dma_start = 1'b0;
    endtask

    task automatic wait_idle(input string tag, input int limit);
        logic done;
        done = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (!dma_busy && exp_q.size() == 0) begin
                done = 1'b1;
                break;
            end
        end
        chk(tag, 32'(done), 32'd1);
    endtask

    initial begin
        int base;
        logic hit;
        rst         = 1'b0;
        reg_wr_en   = 1'b0;
        reg_addr    = 3'd0;
        reg_wr_data = 8'h00;
        dma_start   = 1'b0;
        dma_page    = 8'h00;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            32'({bus_rd_en, bus_addr, spram_wr_en, cpu_halt, dma_busy, oam_drop}),
            32'd0);
        chk("reset_oam", 32'({spram_wr_addr, spram_wr_data, oam_addr}), 32'd0);
        rst = 1'b1;

        // Register path with 8-bit address wrap
        reg_write(3'd3, 8'hFE);
        m_oam = 8'hFE;
        exp_q.push_back({8'hFE, 8'hAA});
        reg_write(3'd4, 8'hAA);
        exp_q.push_back({8'hFF, 8'hBB});
        reg_write(3'd4, 8'hBB);
        exp_q.push_back({8'h00, 8'hCC});
        reg_write(3'd4, 8'hCC);
        m_oam = 8'h01;
        repeat (2) @(negedge clk);
        chk("reg_oam_addr", 32'(oam_addr), 32'(m_oam));
        chk("reg_queue_drained", 32'(exp_q.size()), 32'd0);
        reg_write(3'd5, 8'h77);
        repeat (2) @(negedge clk);
        chk("other_reg_ignored", 32'(oam_addr), 32'(m_oam));

        // Busy hold-off: first byte parks, second is dropped
        busy_force = 1'b1;
        base = wr_cnt;
        drop_cnt = 0;
        repeat (2) @(negedge clk);
        exp_q.push_back({m_oam, 8'h11});
        reg_write(3'd4, 8'h11);
        m_oam = m_oam + 8'd1;
        reg_write(3'd4, 8'h22);
        repeat (4) @(negedge clk);
        chk("busy_no_write", 32'(wr_cnt - base), 32'd0);
        chk("busy_drop_count", 32'(drop_cnt), 32'd1);
        chk("busy_oam_addr", 32'(oam_addr), 32'(m_oam));
        busy_force = 1'b0;
        repeat (4) @(negedge clk);
        chk("busy_release_writes", 32'(wr_cnt - base), 32'd1);
        chk("busy_queue_drained", 32'(exp_q.size()), 32'd0);

        // Full DMA, single-cycle bus
        reg_write(3'd3, 8'h10);
        m_oam = 8'h10;
        base = wr_cnt;
        dma(8'h02);
        wait_idle("dma_full_done", 2000);
        chk("dma_full_writes", 32'(wr_cnt - base), 32'd256);
        chk("dma_full_halt", 32'(halt_cycles), 32'd770);
        chk("dma_full_oam", 32'(oam_addr), 32'h10);
        chk("dma_full_cpu_halt_low", 32'(cpu_halt), 32'd0);

        // Random bus latency and loader stalls
        lat_max = 3;
        busy_mode = 1'b1;
        base = wr_cnt;
        dma(8'h33);
        wait_idle("dma_stall_done", 20000);
        busy_mode = 1'b0;
        lat_max = 0;
        chk("dma_stall_writes", 32'(wr_cnt - base), 32'd256);
        chk("dma_stall_oam", 32'(oam_addr), 32'h10);
        chk("dma_stall_halt_min", 32'(halt_cycles >= 770), 32'd1);

        // Reg write coincident with dma_start, then collisions mid-DMA
        repeat (2) @(negedge clk);
        m_oam = 8'h40;
        exp_page = 8'h05;
        push_dma(8'h40);
        base = wr_cnt;
        @(negedge clk);
        reg_wr_en   = 1'b1;
        reg_addr    = 3'd3;
        reg_wr_data = 8'h40;
        dma_start   = 1'b1;
        dma_page    = 8'h05;
        @(negedge clk);
        reg_wr_en   = 1'b0;
        dma_start   = 1'b0;
        repeat (50) @(negedge clk);
        dma_start   = 1'b1;
        dma_page    = 8'h77;
        reg_wr_en   = 1'b1;
        reg_addr    = 3'd3;
        reg_wr_data = 8'h99;
        @(negedge clk);
        dma_start   = 1'b0;
        reg_addr    = 3'd4;
        reg_wr_data = 8'h55;
        @(negedge clk);
        reg_wr_en   = 1'b0;
        wait_idle("dma_collide_done", 2000);
        chk("dma_collide_writes", 32'(wr_cnt - base), 32'd256);
        chk("dma_collide_oam", 32'(oam_addr), 32'h40);

        // Asynchronous reset after 100 DMA bytes
        base = wr_cnt;
        dma(8'h06);
        hit = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (wr_cnt - base >= 100) begin
                hit = 1'b1;
                break;
            end
        end
        chk("reset_reach_100", 32'(hit), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("midreset_outputs",
            32'({bus_rd_en, bus_addr, spram_wr_en, cpu_halt, dma_busy, oam_drop}),
            32'd0);
        chk("midreset_oam", 32'({spram_wr_addr, spram_wr_data, oam_addr}), 32'd0);
        chk("midreset_cpu_halt", 32'(cpu_halt), 32'd0);
        exp_q.delete();
        repeat (6) @(negedge clk);
        rst = 1'b1;
        m_oam = 8'h00;
        base = wr_cnt;
        dma(8'h07);
        wait_idle("dma_after_reset_done", 2000);
        chk("dma_after_reset_writes", 32'(wr_cnt - base), 32'd256);
        chk("dma_after_reset_halt", 32'(halt_cycles), 32'd770);
        chk("dma_after_reset_oam", 32'(oam_addr), 32'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ppu_oam_writer.md
# ppu_oam_writer

Write-side controller for the PPU sprite RAM (OAM). It owns the single spram write port and fills it from two sources: CPU register writes to OAMADDR/OAMDATA, and OAM DMA ($4014) page copies from CPU memory. It also supplies the current OAMADDR to the sprite-load FSM, the reader on the other side of the same RAM. Writes are held off while that loader is busy, so the loader never observes a half-updated scan.

## Interface

- DMA_LEN, 256, bytes copied per DMA (legal range 1..256)
- clk  input  1  clock
- rst  input  1  reset, asynchronous, active-low
- reg_wr_en  input  1  one-cycle CPU write strobe to a PPU register
- reg_addr  input  3  PPU register index (3 = OAMADDR, 4 = OAMDATA; all others ignored)
- reg_wr_data  input  8  CPU write data
- dma_start  input  1  one-cycle strobe for a CPU write to $4014
- dma_page  input  8  high address byte of the DMA source page
- bus_rd_en  output  1  one-cycle CPU-bus read request
- bus_addr  output  16  read address, {dma_page, idx[7:0]}
- bus_rd_data  input  8  read data
- bus_rd_valid  input  1  read data valid; arrives at the earliest one cycle after bus_rd_en
- loader_busy  input  1  sprite-load FSM busy; blocks spram writes
- spram_wr_en  output  1  spram write strobe
- spram_wr_addr  output  8  spram write address
- spram_wr_data  output  8  spram write data
- oam_addr  output  8  current OAMADDR (drives the loader's sprite base address)
- cpu_halt  output  1  stalls the CPU while a DMA is in progress
- dma_busy  output  1  high whenever the FSM state is not IDLE
- oam_drop  output  1  one-cycle pulse when an OAMDATA write is discarded

## Operation

- Every output is registered. Reset value of every output is 0. Internal state on reset: state = IDLE, idx = 0, pending entry empty.
- **OAMADDR write (reg 3) in IDLE:** oam_addr <= reg_wr_data on the next edge. An already-pending entry keeps the address it captured.
- **OAMDATA write (reg 4) in IDLE, no entry pending:** capture {oam_addr, data} into the single pending entry. oam_addr increments immediately, with 8-bit wrap (0xFF -> 0x00).
- **OAMDATA write while an entry is pending:** the write is discarded, oam_drop pulses for one cycle, and oam_addr is unchanged.
- **Draining the pending entry:** in any cycle where the entry is pending and loader_busy = 0, issue a one-cycle spram write and clear the entry.
- **Register writes in states other than IDLE** are ignored with no side effects.
- **dma_start in IDLE:** latch dma_page, set idx = 0, and go to HALT. dma_start in any other state is ignored.
- **Simultaneous reg write and dma_start:** the reg write is applied first, then the DMA starts using the updated oam_addr.
- **DMA with an entry pending:** the pending entry is flushed at the first write opportunity, before the first DMA byte is written.
- **FSM states:**
  - IDLE: described above.
  - HALT: cpu_halt = 1; go to READ.
  - READ: bus_rd_en = 1 for exactly one cycle, bus_addr = {page, idx[7:0]}; go to WAIT.
  - WAIT: hold until bus_rd_valid; capture bus_rd_data; go to WRITE.
  - WRITE: if loader_busy, stall in WRITE. Otherwise spram_wr_en = 1, spram_wr_addr = oam_addr, spram_wr_data = captured byte; oam_addr++ and idx++. If idx == DMA_LEN-1 before the increment, go to DONE; else go to READ.
  - DONE: cpu_halt <= 0; go to IDLE.
- **Width and wrap rules:**
  - idx is 9 bits wide.
  - oam_addr wraps at 8 bits, so a DMA starting at oam_addr = 0x10 writes 0x10..0xFF then 0x00..0x0F.
  - After a full 256-byte DMA, oam_addr returns to its start value.
- cpu_halt is 1 from the cycle after dma_start is sampled through the cycle DONE is entered, inclusive.
- **Reset mid-DMA:** everything returns to reset values immediately (asynchronous). There is no partial resume, and cpu_halt drops at once.

## Timing

- OAMADDR write at edge T: oam_addr is valid after T+1.
- OAMDATA write at edge T with loader idle: spram_wr_en is high in cycle T+1.
- While loader_busy is high, the pending write is delayed until the first cycle after loader_busy falls.
- **DMA, zero-wait bus, loader idle:**
  - dma_start sampled at edge T; HALT in T+1.
  - First READ in T+2.
  - Each byte costs 3 cycles (READ, WAIT, WRITE).
  - DONE at T+2+3·DMA_LEN, giving 770 cycles of cpu_halt for DMA_LEN = 256.
- Every cycle of bus_rd_valid latency beyond the first, and every cycle of loader_busy in WRITE, adds exactly one cycle.
- bus_rd_en is never asserted again until the previous read has completed.
- At most one spram write occurs per cycle.

## Test plan

- **Register path:** write OAMADDR = 0xFE, then OAMDATA 0xAA, 0xBB, 0xCC on separate cycles with the loader idle -> spram[0xFE] = 0xAA, spram[0xFF] = 0xBB, spram[0x00] = 0xCC; oam_addr = 0x01.
- **Busy hold-off and drop:** hold loader_busy = 1 and write OAMDATA 0x11 then 0x22 -> no spram_wr_en while busy; oam_drop pulses once, on the 0x22 write. Release busy -> a single write of 0x11 to the original address.
- **Full DMA:** oam_addr = 0x10, dma_page = 0x02, bus returns (addr & 0xFF) ^ 0x5A with 1-cycle latency -> 256 writes; spram[(0x10+i) & 0xFF] = i ^ 0x5A; cpu_halt high for exactly 770 cycles; final oam_addr = 0x10.
- **Stalls:** random 0-3 cycle bus latency plus random loader_busy pulses during DMA -> data still correct; bus_rd_en never asserted while a read is outstanding; no spram write while loader_busy is high.
- **Collisions:** a reg write in the same cycle as dma_start, with OAMADDR = 0x40 -> DMA begins writing at 0x40. A second dma_start mid-DMA is ignored (exactly 256 writes). Register writes during DMA have no effect.
- **Reset mid-DMA:** assert rst after 100 bytes -> all outputs 0 asynchronously, cpu_halt low. A new DMA after reset completes normally starting from oam_addr 0.
